// File: rtl/glycemic_index_calculator_pkg.sv
// ----------------------------------------------------------------------------
// glycemic_pkg
// Shared widths and the per-stage pipeline record for the glycemic index
// square-root pipeline.
//
// Contents:
//   GLYC_IN_W    width of the raw blood-sensor sample
//   GLYC_IDX_W   width of the glycemic index (integer square root)
//   GLYC_REM_W   width of the partial remainder carried between stages
//   GLYC_STAGES  number of pipeline stages, one result bit per stage
//   stage_t      contents of one stage register
//
// Optional feature macro used by files importing this package:
//   GLYC_REMAINDER_EN
// ----------------------------------------------------------------------------
package glycemic_pkg;

    localparam int GLYC_IN_W   = 8;
    localparam int GLYC_IDX_W  = 4;
    localparam int GLYC_REM_W  = 5;
    localparam int GLYC_STAGES = 4;

    // The operand is shifted left by two bits in every stage, so the
    // bit-pair still to be consumed always sits in operand[7:6].
    typedef struct packed {
        logic                  valid;
        logic [GLYC_REM_W-1:0] rem;
        logic [GLYC_IDX_W-1:0] root;
        logic [GLYC_IN_W-1:0]  operand;
    } stage_t;

endpackage : glycemic_pkg

// File: rtl/glycemic_index_calculator_if.sv
// ----------------------------------------------------------------------------
// glycemic_index_calculator_if
// Sample-in / index-out bus of the glycemic index calculator.
//
// Signals:
//   sampleValid    bloodSensor holds a new sample this cycle
//   bloodSensor    unsigned 8-bit sensor reading
//   indexValid     glycemicIndex holds a new result this cycle
//   glycemicIndex  floor(sqrt(sample))
//   remainder      sample - index^2 (only with GLYC_REMAINDER_EN)
//
// Modports:
//   master  sensor side / bench: drives samples, observes results
//   slave   calculator side: consumes samples, drives results
//
// Configuration macro: GLYC_REMAINDER_EN adds the remainder signal.
// ----------------------------------------------------------------------------
interface glycemic_index_calculator_if;
    import glycemic_pkg::*;

    logic                  sampleValid;
    logic [GLYC_IN_W-1:0]  bloodSensor;
    logic                  indexValid;
    logic [GLYC_IDX_W-1:0] glycemicIndex;
`ifdef GLYC_REMAINDER_EN
    logic [GLYC_REM_W-1:0] remainder;

    modport master (
        output sampleValid,
        output bloodSensor,
        input  indexValid,
        input  glycemicIndex,
        input  remainder
    );

    modport slave (
        input  sampleValid,
        input  bloodSensor,
        output indexValid,
        output glycemicIndex,
        output remainder
    );
`else
    modport master (
        output sampleValid,
        output bloodSensor,
        input  indexValid,
        input  glycemicIndex
    );

    modport slave (
        input  sampleValid,
        input  bloodSensor,
        output indexValid,
        output glycemicIndex
    );
`endif

endinterface : glycemic_index_calculator_if

// File: rtl/glycemic_index_calculator_sqrt_stage.sv
// ----------------------------------------------------------------------------
// glycemic_sqrt_stage
// Purely combinational step of the restoring digit-by-digit square root.
// Appends the next operand bit-pair to the partial remainder and tries to
// subtract {root, 2'b01}. On success the remainder is reduced and a 1 is
// shifted into the root, otherwise the remainder is kept and a 0 is
// shifted in.
//
// Ports:
//   remIn    partial remainder from the previous stage
//   rootIn   partial root from the previous stage
//   pair     next two operand bits, MSB first
//   remOut   updated partial remainder
//   rootOut  updated partial root
// ----------------------------------------------------------------------------
module glycemic_sqrt_stage
    import glycemic_pkg::*;
(
    input  logic [GLYC_REM_W-1:0] remIn,
    input  logic [GLYC_IDX_W-1:0] rootIn,
    input  logic [1:0]            pair,
    output logic [GLYC_REM_W-1:0] remOut,
    output logic [GLYC_IDX_W-1:0] rootOut
);

    logic [GLYC_REM_W+1:0] trial;
    logic [GLYC_REM_W+1:0] divisor;
    logic [GLYC_REM_W+1:0] diff;
    logic                  accept;
    logic                  unusedBits;

    // The partial remainder never exceeds 2*root, so the 7-bit trial
    // covers every reachable value and the result always fits back
    // into 5 bits. The root MSB is still zero whenever a stage shifts.
    always_comb begin
        trial   = {remIn, pair};
        divisor = {1'b0, rootIn, 2'b01};
        diff    = trial - divisor;
        accept  = (trial >= divisor);
        remOut  = accept ? diff[GLYC_REM_W-1:0] : trial[GLYC_REM_W-1:0];
        rootOut = {rootIn[GLYC_IDX_W-2:0], accept};
    end

    assign unusedBits = ^{diff[GLYC_REM_W+1:GLYC_REM_W], rootIn[GLYC_IDX_W-1]};

endmodule : glycemic_sqrt_stage

// File: rtl/glycemic_index_calculator.sv
// ----------------------------------------------------------------------------
// glycemic_index_calculator
// Converts the raw 8-bit blood-sensor reading into a 4-bit glycemic index,
// glycemicIndex = floor(sqrt(bloodSensor)). Four pipeline stages each
// resolve one root bit; one sample is accepted per clock, no backpressure.
// The last stage register is the output register: its valid bit follows
// the pipeline every cycle while its data only loads on valid results, so
// the outputs hold between results.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    glycemic_index_calculator_if.slave
//            sampleValid/bloodSensor in, indexValid/glycemicIndex out,
//            remainder out when GLYC_REMAINDER_EN is defined
//
// Configuration macro: GLYC_REMAINDER_EN drives bus.remainder from the
// final-stage remainder, aligned with glycemicIndex/indexValid.
// ----------------------------------------------------------------------------
module glycemic_index_calculator
    import glycemic_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    glycemic_index_calculator_if.slave   bus
);

    localparam int LAST = GLYC_STAGES - 1;

    stage_t stageIn   [GLYC_STAGES];
    stage_t stageNext [GLYC_STAGES];
    stage_t stageReg  [GLYC_STAGES];
    logic   unusedBits;

    // Fresh samples enter with an empty remainder and root.
    assign stageIn[0] = '{valid:   bus.sampleValid,
                          rem:     '0,
                          root:    '0,
                          operand: bus.bloodSensor};

    for (genvar g = 0; g < GLYC_STAGES; g++) begin : gStage
        logic [GLYC_REM_W-1:0] remOut;
        logic [GLYC_IDX_W-1:0] rootOut;

        if (g > 0) begin : gChain
            assign stageIn[g] = stageReg[g-1];
        end

        glycemic_sqrt_stage uStage (
            .remIn   (stageIn[g].rem),
            .rootIn  (stageIn[g].root),
            .pair    (stageIn[g].operand[GLYC_IN_W-1:GLYC_IN_W-2]),
            .remOut  (remOut),
            .rootOut (rootOut)
        );

        assign stageNext[g] = '{valid:   stageIn[g].valid,
                                rem:     remOut,
                                root:    rootOut,
                                operand: {stageIn[g].operand[GLYC_IN_W-3:0], 2'b00}};

        // Inner stages load data every cycle since bubbles carry
        // don't-care data; the last stage loads data only on valid results
        // so the visible index holds between results.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stageReg[g] <= '0;
            end else begin
                stageReg[g].valid <= stageNext[g].valid;
                if ((g != LAST) || stageNext[g].valid) begin
                    stageReg[g].rem     <= stageNext[g].rem;
                    stageReg[g].root    <= stageNext[g].root;
                    stageReg[g].operand <= stageNext[g].operand;
                end
            end
        end
    end

    assign bus.indexValid    = stageReg[LAST].valid;
    assign bus.glycemicIndex = stageReg[LAST].root;

`ifdef GLYC_REMAINDER_EN
    assign bus.remainder = stageReg[LAST].rem;
    assign unusedBits    = ^stageReg[LAST].operand;
`else
    assign unusedBits    = ^{stageReg[LAST].operand, stageReg[LAST].rem};
`endif

endmodule : glycemic_index_calculator

// File: tb/tb_glycemic_index_calculator.sv
// ----------------------------------------------------------------------------
// tb_glycemic_index_calculator
// Directed self-checking bench for glycemic_index_calculator. Inputs change
// on the falling edge; outputs are sampled 1 ns after the rising edge.
// Expected results travel through a 4-deep queue matching the pipeline
// latency; the bench tracks the held index/remainder itself.
// Define GLYC_REMAINDER_EN to also check the remainder port.
// ----------------------------------------------------------------------------
module tb_glycemic_index_calculator;
    import glycemic_pkg::*;

    typedef struct packed {
        logic       v;
        logic [7:0] sample;
        logic [3:0] idx;
        logic [4:0] rem;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    logic [3:0] heldIdx;
    logic [4:0] heldRem;
    exp_t expQ [$];

    always #5 clk = ~clk;

    glycemic_index_calculator_if gif ();

    glycemic_index_calculator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (gif.slave)
    );

    // Golden integer square root by counting up.
    function automatic int isqrtRef(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    // Compare outputs against one retired expectation.
    task automatic checkOutput(input exp_t e);
        checks++;
        assert (gif.indexValid === e.v) else begin
            failures++;
            $error("FAIL indexValid sample=%0d observed=%b expected=%b", e.sample, gif.indexValid, e.v);
        end
        if (e.v) begin
            heldIdx = e.idx;
            heldRem = e.rem;
        end
        checks++;
        assert (gif.glycemicIndex === heldIdx) else begin
            failures++;
            $error("FAIL glycemicIndex sample=%0d observed=%0d expected=%0d", e.sample, gif.glycemicIndex, heldIdx);
        end
`ifdef GLYC_REMAINDER_EN
        checks++;
        assert (gif.remainder === heldRem) else begin
            failures++;
            $error("FAIL remainder sample=%0d observed=%0d expected=%0d", e.sample, gif.remainder, heldRem);
        end
`endif
    endtask

    // Outputs must be cleared while reset is applied.
    task automatic checkReset(input string tag);
        checks++;
        assert (gif.indexValid === 1'b0) else begin
            failures++;
            $error("FAIL %s indexValid observed=%b expected=0", tag, gif.indexValid);
        end
        checks++;
        assert (gif.glycemicIndex === 4'd0) else begin
            failures++;
            $error("FAIL %s glycemicIndex observed=%0d expected=0", tag, gif.glycemicIndex);
        end
`ifdef GLYC_REMAINDER_EN
        checks++;
        assert (gif.remainder === 5'd0) else begin
            failures++;
            $error("FAIL %s remainder observed=%0d expected=0", tag, gif.remainder);
        end
`endif
    endtask

    // After reset the pipeline holds three bubbles ahead of any new sample.
    task automatic resetModel();
        expQ.delete();
        heldIdx = '0;
        heldRem = '0;
        for (int i = 0; i < 3; i++) expQ.push_back('{1'b0, 8'd0, 4'd0, 5'd0});
    endtask

    // Called just after a falling edge: drive one sample, clock it in,
    // check the result retiring at this edge, return at the next falling edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d,
                                 input logic [3:0] eIdx, input logic [4:0] eRem);
        gif.sampleValid = v;
        gif.bloodSensor = d;
        expQ.push_back('{v, d, eIdx, eRem});
        @(posedge clk);
        #1;
        checkOutput(expQ.pop_front());
        @(negedge clk);
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'($urandom_range(0, 255)), 4'd0, 5'd0);
    endtask

    initial begin
        rst_n           = 1'b0;
        gif.sampleValid = 1'b0;
        gif.bloodSensor = '0;

        // Reset held with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            gif.sampleValid = 1'($urandom_range(0, 1));
            gif.bloodSensor = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            checkReset("holdReset");
        end
        @(negedge clk);
        gif.sampleValid = 1'b0;
        rst_n           = 1'b1;
        resetModel();

        // Directed values, one per clock.
        applyStimulus(1'b1, 8'd0,   4'd0,  5'd0);
        applyStimulus(1'b1, 8'd1,   4'd1,  5'd0);
        applyStimulus(1'b1, 8'd5,   4'd2,  5'd1);
        applyStimulus(1'b1, 8'd13,  4'd3,  5'd4);
        applyStimulus(1'b1, 8'd17,  4'd4,  5'd1);
        applyStimulus(1'b1, 8'd28,  4'd5,  5'd3);
        applyStimulus(1'b1, 8'd225, 4'd15, 5'd0);
        applyStimulus(1'b1, 8'd253, 4'd15, 5'd28);
        flush();

        // Stream with a bubble; 99 must not produce a result.
        applyStimulus(1'b1, 8'd16,  4'd4,  5'd0);
        applyStimulus(1'b0, 8'd99,  4'd0,  5'd0);
        applyStimulus(1'b1, 8'd100, 4'd10, 5'd0);
        applyStimulus(1'b1, 8'd255, 4'd15, 5'd30);
        flush();

        // Every input value against the golden root.
        for (int x = 0; x < 256; x++) begin
            int r;
            r = isqrtRef(x);
            applyStimulus(1'b1, 8'(x), 4'(r), 5'(x - r * r));
        end
        flush();

        // Asynchronous reset in the middle of a stream of results.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'd225, 4'd15, 5'd0);
        gif.sampleValid = 1'b1;
        gif.bloodSensor = 8'd200;
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("asyncReset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            gif.sampleValid = 1'($urandom_range(0, 1));
            gif.bloodSensor = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            checkReset("resetLow");
        end

        // Release with no samples: nothing in flight may emerge.
        @(negedge clk);
        gif.sampleValid = 1'b0;
        rst_n           = 1'b1;
        resetModel();
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'($urandom_range(0, 255)), 4'd0, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_glycemic_index_calculator
